// File: rtl/mips_multicycle_control.sv
// Main control FSM for the multicycle MIPS core: sequences fetch/decode/execute/
// memory/writeback, handshakes with variable-latency memory and halts on faults.
module mips_multicycle_control #(
  parameter int unsigned ALU_CTRL_W   = 4,
  parameter int unsigned WAIT_TIMEOUT = 15,
  parameter bit          SUPPORT_JAL  = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [5:0]            opcode_i,
  input  logic [5:0]            funct_i,
  input  logic                  zero_i,
  input  logic                  mem_ready_i,
  output logic                  pc_write_o,
  output logic [1:0]            pc_src_o,
  output logic                  iord_o,
  output logic                  mem_req_o,
  output logic                  mem_write_o,
  output logic                  ir_write_o,
  output logic                  reg_write_o,
  output logic [1:0]            reg_dst_o,
  output logic [1:0]            mem_to_reg_o,
  output logic                  alu_src_a_o,
  output logic [1:0]            alu_src_b_o,
  output logic                  imm_zext_o,
  output logic [ALU_CTRL_W-1:0] alu_control_o,
  output logic                  illegal_instr_o,
  output logic                  bus_error_o,
  output logic [3:0]            state_o
);

  localparam int unsigned CNT_W = 8;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMRD    = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWR    = 4'd5,
    S_RTYPE_EX = 4'd6,
    S_ALU_WB   = 4'd7,
    S_BRANCH   = 4'd8,
    S_IMM_EX   = 4'd9,
    S_IMM_WB   = 4'd10,
    S_JUMP     = 4'd11,
    S_JAL      = 4'd12,
    S_HALT     = 4'd13
  } state_e;

  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SUB  = 4'b0001;
  localparam logic [3:0] ALU_AND  = 4'b0010;
  localparam logic [3:0] ALU_OR   = 4'b0011;
  localparam logic [3:0] ALU_XOR  = 4'b0100;
  localparam logic [3:0] ALU_SLL  = 4'b0101;
  localparam logic [3:0] ALU_SRL  = 4'b0110;
  localparam logic [3:0] ALU_SRA  = 4'b0111;
  localparam logic [3:0] ALU_SLT  = 4'b1000;
  localparam logic [3:0] ALU_SLTU = 4'b1001;
  localparam logic [3:0] ALU_NOR  = 4'b1010;
  localparam logic [3:0] ALU_SLLV = 4'b1011;
  localparam logic [3:0] ALU_SRLV = 4'b1100;
  localparam logic [3:0] ALU_SRAV = 4'b1101;
  localparam logic [3:0] ALU_LUI  = 4'b1110;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ADDIU = 6'b001001;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_SLTIU = 6'b001011;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_XORI  = 6'b001110;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               illegal_q, illegal_d;
  logic               bus_err_q, bus_err_d;

  logic [3:0] funct_alu;
  logic       funct_ok;
  logic [3:0] imm_alu;
  logic       imm_zext;
  logic       in_mem_state;
  logic       mem_timeout;

  logic       pc_write_c, iord_c, mem_req_c, mem_write_c, ir_write_c, reg_write_c;
  logic       alu_src_a_c, imm_zext_c;
  logic [1:0] pc_src_c, reg_dst_c, mem_to_reg_c, alu_src_b_c;
  logic [3:0] alu_c;

  // R-type funct to ALU operation
  always_comb begin
    funct_alu = ALU_ADD;
    funct_ok  = 1'b1;
    case (funct_i)
      6'b100000, 6'b100001: funct_alu = ALU_ADD;
      6'b100010, 6'b100011: funct_alu = ALU_SUB;
      6'b100100:            funct_alu = ALU_AND;
      6'b100101:            funct_alu = ALU_OR;
      6'b100110:            funct_alu = ALU_XOR;
      6'b100111:            funct_alu = ALU_NOR;
      6'b101010:            funct_alu = ALU_SLT;
      6'b101011:            funct_alu = ALU_SLTU;
      6'b000000:            funct_alu = ALU_SLL;
      6'b000010:            funct_alu = ALU_SRL;
      6'b000011:            funct_alu = ALU_SRA;
      6'b000100:            funct_alu = ALU_SLLV;
      6'b000110:            funct_alu = ALU_SRLV;
      6'b000111:            funct_alu = ALU_SRAV;
      default:              funct_ok  = 1'b0;
    endcase
  end

  // I-type opcode to ALU operation and immediate extension
  always_comb begin
    imm_alu  = ALU_ADD;
    imm_zext = 1'b0;
    case (opcode_i)
      OP_ANDI:  begin imm_alu = ALU_AND; imm_zext = 1'b1; end
      OP_ORI:   begin imm_alu = ALU_OR;  imm_zext = 1'b1; end
      OP_XORI:  begin imm_alu = ALU_XOR; imm_zext = 1'b1; end
      OP_SLTI:  imm_alu = ALU_SLT;
      OP_SLTIU: imm_alu = ALU_SLTU;
      OP_LUI:   imm_alu = ALU_LUI;
      default:  imm_alu = ALU_ADD;
    endcase
  end

  assign in_mem_state = (state_q == S_FETCH) || (state_q == S_MEMRD) || (state_q == S_MEMWR);
  assign mem_timeout  = in_mem_state && !mem_ready_i && (cnt_q == CNT_W'(WAIT_TIMEOUT));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_FETCH;
      cnt_q     <= '0;
      illegal_q <= 1'b0;
      bus_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      illegal_q <= illegal_d;
      bus_err_q <= bus_err_d;
    end
  end

  // Next state and Moore outputs; ready-qualified enables in FETCH, zero-qualified pc_write in BRANCH
  always_comb begin
    state_d      = state_q;
    illegal_d    = illegal_q;
    bus_err_d    = bus_err_q;
    pc_write_c   = 1'b0;
    pc_src_c     = 2'b00;
    iord_c       = 1'b0;
    mem_req_c    = 1'b0;
    mem_write_c  = 1'b0;
    ir_write_c   = 1'b0;
    reg_write_c  = 1'b0;
    reg_dst_c    = 2'b00;
    mem_to_reg_c = 2'b00;
    alu_src_a_c  = 1'b0;
    alu_src_b_c  = 2'b00;
    imm_zext_c   = 1'b0;
    alu_c        = ALU_ADD;
    case (state_q)
      S_FETCH: begin
        mem_req_c   = 1'b1;
        alu_src_b_c = 2'b01;
        if (mem_ready_i) begin
          ir_write_c = 1'b1;
          pc_write_c = 1'b1;
          state_d    = S_DECODE;
        end else if (mem_timeout) begin
          state_d   = S_HALT;
          bus_err_d = 1'b1;
        end
      end
      S_DECODE: begin
        alu_src_b_c = 2'b11;
        case (opcode_i)
          OP_LW, OP_SW:   state_d = S_MEMADR;
          OP_RTYPE:       state_d = S_RTYPE_EX;
          OP_BEQ, OP_BNE: state_d = S_BRANCH;
          OP_ADDI, OP_ADDIU, OP_ANDI, OP_ORI, OP_XORI, OP_SLTI, OP_SLTIU, OP_LUI:
                          state_d = S_IMM_EX;
          OP_J:           state_d = S_JUMP;
          OP_JAL: begin
            if (SUPPORT_JAL) begin
              state_d = S_JAL;
            end else begin
              state_d   = S_HALT;
              illegal_d = 1'b1;
            end
          end
          default: begin
            state_d   = S_HALT;
            illegal_d = 1'b1;
          end
        endcase
      end
      S_MEMADR: begin
        alu_src_a_c = 1'b1;
        alu_src_b_c = 2'b10;
        state_d     = (opcode_i == OP_LW) ? S_MEMRD : S_MEMWR;
      end
      S_MEMRD: begin
        mem_req_c = 1'b1;
        iord_c    = 1'b1;
        if (mem_ready_i) begin
          state_d = S_MEMWB;
        end else if (mem_timeout) begin
          state_d   = S_HALT;
          bus_err_d = 1'b1;
        end
      end
      S_MEMWB: begin
        reg_write_c  = 1'b1;
        mem_to_reg_c = 2'b01;
        state_d      = S_FETCH;
      end
      S_MEMWR: begin
        mem_req_c   = 1'b1;
        mem_write_c = 1'b1;
        iord_c      = 1'b1;
        if (mem_ready_i) begin
          state_d = S_FETCH;
        end else if (mem_timeout) begin
          state_d   = S_HALT;
          bus_err_d = 1'b1;
        end
      end
      S_RTYPE_EX: begin
        alu_src_a_c = 1'b1;
        alu_c       = funct_alu;
        if (funct_ok) begin
          state_d = S_ALU_WB;
        end else begin
          state_d   = S_HALT;
          illegal_d = 1'b1;
        end
      end
      S_ALU_WB: begin
        reg_write_c = 1'b1;
        reg_dst_c   = 2'b01;
        state_d     = S_FETCH;
      end
      S_BRANCH: begin
        alu_src_a_c = 1'b1;
        alu_c       = ALU_SUB;
        pc_src_c    = 2'b01;
        pc_write_c  = zero_i ^ (opcode_i == OP_BNE);
        state_d     = S_FETCH;
      end
      S_IMM_EX: begin
        alu_src_a_c = 1'b1;
        alu_src_b_c = 2'b10;
        imm_zext_c  = imm_zext;
        alu_c       = imm_alu;
        state_d     = S_IMM_WB;
      end
      S_IMM_WB: begin
        reg_write_c = 1'b1;
        state_d     = S_FETCH;
      end
      S_JUMP: begin
        pc_write_c = 1'b1;
        pc_src_c   = 2'b10;
        state_d    = S_FETCH;
      end
      S_JAL: begin
        reg_write_c  = 1'b1;
        reg_dst_c    = 2'b10;
        mem_to_reg_c = 2'b10;
        pc_write_c   = 1'b1;
        pc_src_c     = 2'b10;
        state_d      = S_FETCH;
      end
      S_HALT:  state_d = S_HALT;
      default: state_d = S_FETCH;
    endcase
  end

  // Wait counter: cleared on every state change, counts unanswered memory cycles
  always_comb begin
    cnt_d = cnt_q;
    if (state_d != state_q) begin
      cnt_d = '0;
    end else if (in_mem_state && !mem_ready_i) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // Enables drop the instant reset asserts so no partial write can escape
  assign pc_write_o      = pc_write_c  & rst_n;
  assign mem_req_o       = mem_req_c   & rst_n;
  assign mem_write_o     = mem_write_c & rst_n;
  assign ir_write_o      = ir_write_c  & rst_n;
  assign reg_write_o     = reg_write_c & rst_n;
  assign pc_src_o        = pc_src_c;
  assign iord_o          = iord_c;
  assign reg_dst_o       = reg_dst_c;
  assign mem_to_reg_o    = mem_to_reg_c;
  assign alu_src_a_o     = alu_src_a_c;
  assign alu_src_b_o     = alu_src_b_c;
  assign imm_zext_o      = imm_zext_c;
  assign alu_control_o   = ALU_CTRL_W'(alu_c);
  assign illegal_instr_o = illegal_q;
  assign bus_error_o     = bus_err_q;
  assign state_o         = 4'(state_q);

endmodule

// File: tb/tb_mips_multicycle_control.sv
// Bench for mips_multicycle_control: per-cycle expected output vectors are queued
// with their mem_ready stimulus and compared as the FSM steps through each scenario.
module tb_mips_multicycle_control;

  typedef struct packed {
    logic [3:0] st;
    logic       pw;
    logic [1:0] ps;
    logic       iord;
    logic       mreq;
    logic       mwr;
    logic       irw;
    logic       rw;
    logic [1:0] rdst;
    logic [1:0] m2r;
    logic       asa;
    logic [1:0] asb;
    logic       zext;
    logic [3:0] alu;
    logic       ill;
    logic       be;
  } obs_t;

  typedef struct packed {
    logic rdy;
    obs_t o;
  } sb_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [5:0] opcode = 6'd0;
  logic [5:0] funct = 6'd0;
  logic       zero = 1'b0;
  logic       mem_ready = 1'b0;

  logic       pc_write, iord, mem_req, mem_write, ir_write, reg_write;
  logic       alu_src_a, imm_zext, illegal, bus_error;
  logic [1:0] pc_src, reg_dst, mem_to_reg, alu_src_b;
  logic [3:0] alu_control, state;

  logic       d2_pc_write, d2_iord, d2_mem_req, d2_mem_write, d2_ir_write, d2_reg_write;
  logic       d2_alu_src_a, d2_imm_zext, d2_illegal, d2_bus_error;
  logic [1:0] d2_pc_src, d2_reg_dst, d2_mem_to_reg, d2_alu_src_b;
  logic [3:0] d2_alu_control, d2_state;

  obs_t obs;
  sb_t  sb_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  logic exp_ill = 1'b0;
  logic exp_be  = 1'b0;
  logic rw_watch = 1'b0;
  logic saw_rw = 1'b0;

  always #5 clk = ~clk;

  mips_multicycle_control #(.ALU_CTRL_W(4), .WAIT_TIMEOUT(15), .SUPPORT_JAL(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .opcode_i(opcode), .funct_i(funct), .zero_i(zero),
    .mem_ready_i(mem_ready), .pc_write_o(pc_write), .pc_src_o(pc_src), .iord_o(iord),
    .mem_req_o(mem_req), .mem_write_o(mem_write), .ir_write_o(ir_write),
    .reg_write_o(reg_write), .reg_dst_o(reg_dst), .mem_to_reg_o(mem_to_reg),
    .alu_src_a_o(alu_src_a), .alu_src_b_o(alu_src_b), .imm_zext_o(imm_zext),
    .alu_control_o(alu_control), .illegal_instr_o(illegal), .bus_error_o(bus_error),
    .state_o(state)
  );

  mips_multicycle_control #(.ALU_CTRL_W(4), .WAIT_TIMEOUT(15), .SUPPORT_JAL(1'b0)) dut_nojal (
    .clk(clk), .rst_n(rst_n), .opcode_i(opcode), .funct_i(funct), .zero_i(zero),
    .mem_ready_i(mem_ready), .pc_write_o(d2_pc_write), .pc_src_o(d2_pc_src), .iord_o(d2_iord),
    .mem_req_o(d2_mem_req), .mem_write_o(d2_mem_write), .ir_write_o(d2_ir_write),
    .reg_write_o(d2_reg_write), .reg_dst_o(d2_reg_dst), .mem_to_reg_o(d2_mem_to_reg),
    .alu_src_a_o(d2_alu_src_a), .alu_src_b_o(d2_alu_src_b), .imm_zext_o(d2_imm_zext),
    .alu_control_o(d2_alu_control), .illegal_instr_o(d2_illegal), .bus_error_o(d2_bus_error),
    .state_o(d2_state)
  );

  assign obs = {state, pc_write, pc_src, iord, mem_req, mem_write, ir_write, reg_write,
                reg_dst, mem_to_reg, alu_src_a, alu_src_b, imm_zext, alu_control,
                illegal, bus_error};

  always @(negedge clk) if (rw_watch && reg_write) saw_rw <= 1'b1;

  // Expected Moore outputs per state; FETCH assumes a completing (ready) cycle
  function automatic obs_t mk(input logic [3:0] st);
    obs_t o;
    o = '0;
    o.st  = st;
    o.ill = exp_ill;
    o.be  = exp_be;
    case (st)
      4'd0:  begin o.mreq = 1'b1; o.asb = 2'b01; o.irw = 1'b1; o.pw = 1'b1; end
      4'd1:  o.asb = 2'b11;
      4'd2:  begin o.asa = 1'b1; o.asb = 2'b10; end
      4'd3:  begin o.mreq = 1'b1; o.iord = 1'b1; end
      4'd4:  begin o.rw = 1'b1; o.m2r = 2'b01; end
      4'd5:  begin o.mreq = 1'b1; o.mwr = 1'b1; o.iord = 1'b1; end
      4'd6:  o.asa = 1'b1;
      4'd7:  begin o.rw = 1'b1; o.rdst = 2'b01; end
      4'd8:  begin o.asa = 1'b1; o.alu = 4'b0001; o.ps = 2'b01; end
      4'd9:  begin o.asa = 1'b1; o.asb = 2'b10; end
      4'd10: o.rw = 1'b1;
      4'd11: begin o.pw = 1'b1; o.ps = 2'b10; end
      4'd12: begin o.rw = 1'b1; o.rdst = 2'b10; o.m2r = 2'b10; o.pw = 1'b1; o.ps = 2'b10; end
      default: ;
    endcase
    return o;
  endfunction

  function automatic obs_t fetch_wait();
    obs_t o;
    o = mk(4'd0);
    o.irw = 1'b0;
    o.pw  = 1'b0;
    return o;
  endfunction

  task automatic push(input logic rdy, input obs_t o);
    sb_q.push_back({rdy, o});
  endtask

  // Scoreboard consumer: drive each entry's mem_ready, compare at the falling edge
  task automatic run_sb(input string name);
    sb_t e;
    int  idx;
    idx = 0;
    while (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      mem_ready = e.rdy;
      @(negedge clk);
      n_tests++;
      if (obs !== e.o) begin
        n_fail++;
        $display("FAIL %s cyc%0d: got st=%0d vec=%h, want st=%0d vec=%h",
                 name, idx, obs.st, obs, e.o.st, e.o);
      end
      @(posedge clk);
      #1;
      idx++;
    end
  endtask

  task automatic apply_reset(input string name);
    obs_t e;
    rst_n = 1'b0;
    mem_ready = 1'b1;
    exp_ill = 1'b0;
    exp_be  = 1'b0;
    repeat (3) begin
      @(negedge clk);
      e = mk(4'd0);
      e.mreq = 1'b0;
      e.irw  = 1'b0;
      e.pw   = 1'b0;
      n_tests++;
      if (obs !== e) begin
        n_fail++;
        $display("FAIL %s: got vec=%h, want vec=%h", name, obs, e);
      end
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    opcode = 6'b100011;
    apply_reset("reset_hold");
  endtask

  task automatic test_lw();
    opcode = 6'b100011;
    push(1'b1, mk(4'd0));
    push(1'b1, mk(4'd1));
    push(1'b1, mk(4'd2));
    push(1'b1, mk(4'd3));
    push(1'b1, mk(4'd4));
    run_sb("lw");
    n_tests++;
    if (state !== 4'd0) begin
      n_fail++;
      $display("FAIL lw_return: got state=%0d, want 0", state);
    end
  endtask

  task automatic test_rtype();
    logic [5:0] fn [5];
    logic [3:0] al [5];
    obs_t o;
    fn = '{6'b100010, 6'b100111, 6'b000111, 6'b101011, 6'b000000};
    al = '{4'b0001, 4'b1010, 4'b1101, 4'b1001, 4'b0101};
    opcode = 6'b000000;
    for (int i = 0; i < 5; i++) begin
      funct = fn[i];
      push(1'b1, mk(4'd0));
      push(1'b1, mk(4'd1));
      o = mk(4'd6);
      o.alu = al[i];
      push(1'b1, o);
      push(1'b1, mk(4'd7));
      run_sb($sformatf("rtype_f%b", fn[i]));
    end
  endtask

  task automatic test_branch();
    logic [5:0] op [4];
    logic       z  [4];
    logic       pw [4];
    obs_t o;
    op = '{6'b000101, 6'b000101, 6'b000100, 6'b000100};
    z  = '{1'b0, 1'b1, 1'b1, 1'b0};
    pw = '{1'b1, 1'b0, 1'b1, 1'b0};
    for (int i = 0; i < 4; i++) begin
      opcode = op[i];
      zero   = z[i];
      push(1'b1, mk(4'd0));
      push(1'b1, mk(4'd1));
      o = mk(4'd8);
      o.pw = pw[i];
      push(1'b1, o);
      run_sb($sformatf("branch_op%b_z%0d", op[i], z[i]));
    end
    zero = 1'b0;
  endtask

  task automatic test_imm();
    logic [5:0] op [5];
    logic [3:0] al [5];
    logic       zx [5];
    obs_t o;
    op = '{6'b001101, 6'b001111, 6'b001011, 6'b001110, 6'b001000};
    al = '{4'b0011, 4'b1110, 4'b1001, 4'b0100, 4'b0000};
    zx = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    for (int i = 0; i < 5; i++) begin
      opcode = op[i];
      push(1'b1, mk(4'd0));
      push(1'b1, mk(4'd1));
      o = mk(4'd9);
      o.alu  = al[i];
      o.zext = zx[i];
      push(1'b1, o);
      push(1'b1, mk(4'd10));
      run_sb($sformatf("imm_op%b", op[i]));
    end
  endtask

  task automatic test_jump();
    opcode = 6'b000010;
    push(1'b1, mk(4'd0));
    push(1'b1, mk(4'd1));
    push(1'b1, mk(4'd11));
    run_sb("jump");
    opcode = 6'b000011;
    push(1'b1, mk(4'd0));
    push(1'b1, mk(4'd1));
    push(1'b1, mk(4'd12));
    run_sb("jal");
    n_tests++;
    if (d2_state !== 4'd13 || d2_illegal !== 1'b1 || d2_reg_write !== 1'b0) begin
      n_fail++;
      $display("FAIL jal_disabled: got state=%0d ill=%0b rw=%0b, want state=13 ill=1 rw=0",
               d2_state, d2_illegal, d2_reg_write);
    end
  endtask

  task automatic test_sw_wait();
    opcode = 6'b101011;
    push(1'b1, mk(4'd0));
    push(1'b1, mk(4'd1));
    push(1'b1, mk(4'd2));
    repeat (5) push(1'b0, mk(4'd5));
    push(1'b1, mk(4'd5));
    run_sb("sw_wait");
    n_tests++;
    if (state !== 4'd0) begin
      n_fail++;
      $display("FAIL sw_return: got state=%0d, want 0", state);
    end
  endtask

  task automatic test_timeout();
    opcode = 6'b000010;
    repeat (15) push(1'b0, fetch_wait());
    push(1'b1, mk(4'd0));
    push(1'b1, mk(4'd1));
    push(1'b1, mk(4'd11));
    repeat (16) push(1'b0, fetch_wait());
    exp_be = 1'b1;
    push(1'b0, mk(4'd13));
    push(1'b1, mk(4'd13));
    push(1'b1, mk(4'd13));
    run_sb("timeout");
  endtask

  task automatic test_illegal();
    obs_t o;
    apply_reset("reset_before_illop");
    opcode = 6'b111111;
    push(1'b1, mk(4'd0));
    push(1'b1, mk(4'd1));
    exp_ill = 1'b1;
    push(1'b1, mk(4'd13));
    push(1'b1, mk(4'd13));
    run_sb("illegal_opcode");
    apply_reset("reset_before_illfn");
    opcode = 6'b000000;
    funct  = 6'b001000;
    push(1'b1, mk(4'd0));
    push(1'b1, mk(4'd1));
    o = mk(4'd6);
    push(1'b1, o);
    exp_ill = 1'b1;
    push(1'b1, mk(4'd13));
    push(1'b1, mk(4'd13));
    run_sb("illegal_funct");
    apply_reset("reset_after_illfn");
  endtask

  task automatic test_reset_mid();
    obs_t e;
    opcode = 6'b100011;
    saw_rw = 1'b0;
    rw_watch = 1'b1;
    push(1'b1, mk(4'd0));
    push(1'b1, mk(4'd1));
    push(1'b1, mk(4'd2));
    push(1'b0, mk(4'd3));
    push(1'b0, mk(4'd3));
    run_sb("memrd_wait");
    mem_ready = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    n_tests++;
    if (state !== 4'd0 || reg_write !== 1'b0 || mem_req !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_async: got state=%0d rw=%0b mreq=%0b, want 0 0 0",
               state, reg_write, mem_req);
    end
    mem_ready = 1'b1;
    @(negedge clk);
    e = mk(4'd0);
    e.mreq = 1'b0;
    e.irw  = 1'b0;
    e.pw   = 1'b0;
    n_tests++;
    if (obs !== e) begin
      n_fail++;
      $display("FAIL reset_mid_hold: got vec=%h, want vec=%h", obs, e);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    rw_watch = 1'b0;
    n_tests++;
    if (saw_rw !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_mid_no_write: got saw_rw=%0b, want 0", saw_rw);
    end
    push(1'b1, mk(4'd0));
    push(1'b1, mk(4'd1));
    push(1'b1, mk(4'd2));
    push(1'b1, mk(4'd3));
    push(1'b1, mk(4'd4));
    run_sb("lw_after_reset");
  endtask

  initial begin
    test_reset();
    test_lw();
    test_rtype();
    test_branch();
    test_imm();
    test_jump();
    test_sw_wait();
    test_timeout();
    test_illegal();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

endmodule

// File: doc/mips_multicycle_control.md
Name: mips_multicycle_control

Overview:
- Main control FSM for the next-generation multicycle MIPS core. It replaces the single-cycle combinational decoder.
- It sequences fetch, decode, execute, memory and writeback over several clocks, and handshakes with a variable-latency memory through mem_req/mem_ready.
- It decodes the same R/I/J subset plus JAL, with a memory-timeout watchdog. It flags illegal instructions and halts on them.
- It sits between the instruction register (opcode/funct) and the multicycle datapath muxes, register file and memory port.

Parameters:
- ALU_CTRL_W, 4, width of alu_control.
- WAIT_TIMEOUT, 15, maximum cycles mem_ready may stay low during a memory state before bus_error (1..255).
- SUPPORT_JAL, 1, when 0, opcode 000011 is treated as illegal.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset
- opcode  in  6  IR[31:26]
- funct  in  6  IR[5:0]
- zero  in  1  ALU zero flag
- mem_ready  in  1  memory handshake completion
- pc_write  out  1  PC register enable
- pc_src  out  2  00 ALU result, 01 ALUOut (branch target), 10 jump target
- iord  out  1  memory address: 0 PC, 1 ALUOut
- mem_req  out  1  memory access request
- mem_write  out  1  write qualifier for mem_req
- ir_write  out  1  IR load enable
- reg_write  out  1  register-file write enable
- reg_dst  out  2  00 rt, 01 rd, 10 $31
- mem_to_reg  out  2  00 ALUOut, 01 MDR, 10 PC
- alu_src_a  out  1  0 PC, 1 rs
- alu_src_b  out  2  00 rt, 01 constant 4, 10 extended imm, 11 sign-extended imm<<2
- imm_zext  out  1  zero-extend imm (ANDI/ORI/XORI)
- alu_control  out  ALU_CTRL_W  ALU operation
- illegal_instr  out  1  sticky illegal-instruction flag
- bus_error  out  1  sticky memory-timeout flag
- state  out  4  current FSM state (debug)

Behaviour:
- Reset: state=FETCH(0).
  - Both flags and the wait counter clear.
  - All outputs are in their FETCH values while reset is held, with mem_req gated low until reset releases.
- States and encoding:
  - FETCH 0, DECODE 1, MEMADR 2, MEMRD 3, MEMWB 4, MEMWR 5, RTYPE_EX 6, ALU_WB 7.
  - BRANCH 8, IMM_EX 9, IMM_WB 10, JUMP 11, JAL 12, HALT 13.
- Output rule: Moore outputs from the state, except pc_write in BRANCH and the handshake-qualified enables.
- Default outputs: every enable 0, every select 0, alu_control ADD.
- ALU encoding: ADD 0000, SUB 0001, AND 0010, OR 0011, XOR 0100, SLL 0101, SRL 0110, SRA 0111, SLT 1000, SLTU 1001, NOR 1010, SLLV 1011, SRLV 1100, SRAV 1101, LUI 1110.
- FETCH:
  - Drives mem_req=1, iord=0, alu_src_b=01, ADD.
  - ir_write and pc_write pulse only in the cycle mem_ready=1, then the FSM moves to DECODE.
- DECODE:
  - Drives alu_src_b=11, ADD, so the branch target goes to ALUOut.
  - Next state by opcode:
    - LW/SW go to MEMADR.
    - R-type goes to RTYPE_EX.
    - BEQ/BNE go to BRANCH.
    - ADDI/ADDIU/ANDI/ORI/XORI/SLTI/SLTIU/LUI go to IMM_EX.
    - J goes to JUMP.
    - JAL goes to JAL when SUPPORT_JAL=1.
    - Anything else goes to HALT with illegal_instr set.
- MEMADR: alu_src_a=1, alu_src_b=10, ADD. Goes to MEMRD (LW) or MEMWR (SW).
- MEMRD: mem_req=1, iord=1. On mem_ready goes to MEMWB.
- MEMWB: reg_write=1, reg_dst=00, mem_to_reg=01, then FETCH.
- MEMWR: mem_req=1, mem_write=1, iord=1. On mem_ready goes to FETCH.
- RTYPE_EX:
  - Drives alu_src_a=1, alu_src_b=00, with alu_control from funct.
  - Funct values: 100000/100001 ADD, 100010/100011 SUB, 100100 AND, 100101 OR, 100110 XOR, 100111 NOR, 101010 SLT, 101011 SLTU, 000000 SLL, 000010 SRL, 000011 SRA, 000100 SLLV, 000110 SRLV, 000111 SRAV.
  - Any other funct goes to HALT with illegal_instr set, and no write occurs.
  - Otherwise goes to ALU_WB.
- ALU_WB: reg_write=1, reg_dst=01, mem_to_reg=00, then FETCH.
- BRANCH:
  - Drives alu_src_a=1, alu_src_b=00, SUB, pc_src=01.
  - pc_write = zero XOR (opcode==000101), combinational in this state.
  - Then FETCH.
- IMM_EX:
  - Drives alu_src_a=1, alu_src_b=10, with imm_zext=1 for ANDI/ORI/XORI.
  - alu_control per opcode: ADD, AND, OR, XOR, SLT, SLTU, LUI.
  - Then IMM_WB.
- IMM_WB: reg_write=1, reg_dst=00, mem_to_reg=00, then FETCH.
- JUMP: pc_write=1, pc_src=10, then FETCH.
- JAL:
  - Drives reg_write=1, reg_dst=10, mem_to_reg=10, so $31 gets the already-incremented PC.
  - Also drives pc_write=1, pc_src=10, then FETCH.
- Wait counter (8 bit):
  - Clears on entry to every memory state, and increments each cycle mem_ready=0 in FETCH/MEMRD/MEMWR.
  - If the count equals WAIT_TIMEOUT with mem_ready still 0: go to HALT with bus_error set.
  - mem_ready=1 in that same cycle wins, and the access completes normally.
  - mem_ready outside memory states is ignored.
- HALT:
  - All enables are 0 and mem_req is 0.
  - The FSM stays in HALT until reset, and the flags hold.
- Reset asserted mid-instruction: immediate return to FETCH with no partial write, because all enables go 0 asynchronously.
- Cycle counts with zero-wait memory (mem_ready high on the first cycle):
  - LW 5 cycles.
  - SW, R-type, I-type 4 cycles.
  - BEQ/BNE, J, JAL 3 cycles.

Test Plan:
- Reset low for 3 cycles, then release with mem_ready=1 and opcode=100011 -> states 0,1,2,3,4,0; reg_write=1 only in state 4 with mem_to_reg=01.
- R-type with funct=100010 and mem_ready=1 -> RTYPE_EX alu_control=0001; ALU_WB has reg_dst=01 and reg_write=1; total 4 cycles.
- BNE (000101) with zero=0 -> pc_write=1 and pc_src=01 in BRANCH; repeat with zero=1 -> pc_write=0.
- SW with mem_ready low for 5 cycles in MEMWR -> mem_req and mem_write held for 6 cycles, FETCH follows; then hold mem_ready=0 in FETCH past 15 waits -> HALT, bus_error=1, mem_req=0.
- Opcode 111111 -> HALT after DECODE with illegal_instr=1; R-type funct=001000 -> HALT with no reg_write; SUPPORT_JAL=0 with opcode 000011 -> HALT.
- JAL with SUPPORT_JAL=1 -> reg_write=1, reg_dst=10, mem_to_reg=10, pc_write=1, pc_src=10 in the same cycle; reset pulsed during MEMRD -> state=0 with reg_write never asserted.
